// File: rtl/game_switch_sequencer_pkg.sv
// Shared system constants: the game catalogue and the game-switch sequencer state set.
package system_consts;

    typedef enum logic [1:0] {
        FINALB  = 2'd0,
        DINOREX = 2'd1,
        QJINSEI = 2'd2,
        LIQUIDK = 2'd3
    } game_t;

    // The game the board comes up in after reset is always the first enumerator.
    localparam game_t GAME_RESET = FINALB;

    typedef enum logic [2:0] {
        GSW_IDLE    = 3'd0,
        GSW_HOLD    = 3'd1,
        GSW_SETTLE  = 3'd2,
        GSW_CLEAR   = 3'd3,
        GSW_RELEASE = 3'd4
    } gsw_state_t;

    function automatic int gsw_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_switch_sequencer_if.sv
// Request/status bundle between the game-select logic (master) and the sequencer (slave).
interface game_switch_sequencer_if;
    import system_consts::*;

    game_t       game_req;
    logic        req_valid;
    game_t       game;
    logic        core_reset_n;
    logic [15:0] clr_addr;
    logic        clr_we;
    logic        busy;

    modport master (
        output game_req, req_valid,
        input  game, core_reset_n, clr_addr, clr_we, busy
    );

    modport slave (
        input  game_req, req_valid,
        output game, core_reset_n, clr_addr, clr_we, busy
    );

endinterface

// File: rtl/game_switch_sequencer.sv
// Game switch sequencer: holds the game core in reset, swaps the active game, lets the
// board config settle, zeroes work RAM, then releases the core.
module game_switch_sequencer
    import system_consts::*;
#(
    parameter int RST_HOLD  = 16,
    parameter int SETTLE    = 2,
    parameter int CLR_WORDS = 256
) (
    input logic clk,
    input logic reset_n,
    game_switch_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'(GSW_IDLE);
    localparam logic [2:0] S_HOLD    = 3'(GSW_HOLD);
    localparam logic [2:0] S_SETTLE  = 3'(GSW_SETTLE);
    localparam logic [2:0] S_CLEAR   = 3'(GSW_CLEAR);
    localparam logic [2:0] S_RELEASE = 3'(GSW_RELEASE);

    localparam int CNT_W  = $clog2(gsw_max(RST_HOLD, SETTLE) + 1);
    localparam int ADDR_W = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LOAD   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(CLR_WORDS - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    game_t             game_q, game_d;
    game_t             tgt_q, tgt_d;
    logic              pend_v_q, pend_v_d;
    game_t             pend_g_q, pend_g_d;
    logic              crst_n_q, crst_n_d;

    logic              eff_v;
    game_t             eff_g;

    // A strobe landing in RELEASE itself wins over the older pending entry.
    assign eff_v = bus.req_valid | pend_v_q;
    assign eff_g = bus.req_valid ? bus.game_req : pend_g_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        game_d   = game_q;
        tgt_d    = tgt_q;
        pend_v_d = pend_v_q;
        pend_g_d = pend_g_q;
        crst_n_d = crst_n_q;

        if (bus.req_valid && (state_q != S_IDLE)) begin
            pend_v_d = 1'b1;
            pend_g_d = bus.game_req;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && (bus.game_req != game_q)) begin
                    tgt_d    = bus.game_req;
                    cnt_d    = HOLD_LOAD;
                    crst_n_d = 1'b0;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    game_d  = tgt_q;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    addr_d  = '0;
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CLEAR: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d   = '0;
                    crst_n_d = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_RELEASE: begin
                pend_v_d = 1'b0;
                if (eff_v && (eff_g != game_q)) begin
                    tgt_d    = eff_g;
                    cnt_d    = HOLD_LOAD;
                    crst_n_d = 1'b0;
                    state_d  = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset lands in HOLD so every power-up runs a full reset-and-clear pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_HOLD;
            cnt_q    <= HOLD_LOAD;
            addr_q   <= '0;
            game_q   <= GAME_RESET;
            tgt_q    <= GAME_RESET;
            pend_v_q <= 1'b0;
            pend_g_q <= GAME_RESET;
            crst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            game_q   <= game_d;
            tgt_q    <= tgt_d;
            pend_v_q <= pend_v_d;
            pend_g_q <= pend_g_d;
            crst_n_q <= crst_n_d;
        end
    end

    assign bus.game         = game_q;
    assign bus.core_reset_n = crst_n_q;
    assign bus.clr_addr     = 16'(addr_q);
    assign bus.clr_we       = (state_q == S_CLEAR);
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: doc/game_switch_sequencer.md
GAME_SWITCH_SEQUENCER -- requirements
Module: game_switch_sequencer

Interface
REQ-001 The module SHALL have parameter RST_HOLD, default 16, which sets the number of cycles core reset is held before the new game is applied (legal range 1..255).
REQ-002 The module SHALL have parameter SETTLE, default 2, which sets the number of cycles allowed for registered board config to settle (legal range 1..15).
REQ-003 The module SHALL have parameter CLR_WORDS, default 256, which sets the number of work-RAM words cleared per switch (legal range 1..65536).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The module SHALL have port reset_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-006 The module SHALL have port game_req, input, game_t, the requested game.
REQ-007 The module SHALL have port req_valid, input, 1 bit, a one-cycle request strobe.
REQ-008 The module SHALL have port game, output, game_t, the active game fed to the board config block.
REQ-009 The module SHALL have port core_reset_n, output, 1 bit, the game-core reset; 0 means held in reset.
REQ-010 The module SHALL have port clr_addr, output, 16 bits, the work-RAM clear address.
REQ-011 The module SHALL have port clr_we, output, 1 bit, the work-RAM clear write strobe (data is implicitly zero).
REQ-012 The module SHALL have port busy, output, 1 bit, which is high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, HOLD, SETTLE, CLEAR, RELEASE.
REQ-014 IDLE: when req_valid=1 and game_req differs from game, the FSM SHALL latch game_req and enter HOLD on the next edge; when game_req equals game, the request SHALL be ignored.
REQ-015 HOLD: core_reset_n SHALL be 0; the FSM SHALL stay for exactly RST_HOLD cycles, then load game from the latched request and enter SETTLE.
REQ-016 SETTLE: core_reset_n SHALL be 0; the FSM SHALL stay for exactly SETTLE cycles, then enter CLEAR with clr_addr=0.
REQ-017 CLEAR: clr_we SHALL be 1 every cycle and clr_addr SHALL increment by 1 per cycle from 0 to CLR_WORDS-1 with no wrap; after the write to CLR_WORDS-1 the FSM SHALL enter RELEASE.
REQ-018 RELEASE: core_reset_n SHALL go to 1 on entry; the FSM SHALL stay exactly one cycle, then enter IDLE.
REQ-019 Outside CLEAR, clr_we SHALL be 0 and clr_addr SHALL be 0.
REQ-020 A req_valid arriving while busy=1 SHALL be captured in a one-deep pending register, with the latest request overwriting any earlier one.
REQ-021 In RELEASE, when a pending request exists and differs from game, the FSM SHALL go to HOLD instead of IDLE, consuming the pending request; otherwise the pending request SHALL be discarded.
REQ-022 A req_valid arriving in the same cycle the FSM leaves RELEASE SHALL be treated as pending and SHALL be evaluated against the game value being committed.
REQ-023 game SHALL change only on the HOLD-to-SETTLE transition, never while core_reset_n=1.
REQ-024 Latency SHALL be: from a req_valid accepted at edge T, core_reset_n=0 from T+1 through T+RST_HOLD+SETTLE+CLR_WORDS, and 1 from T+RST_HOLD+SETTLE+CLR_WORDS+1.
REQ-025 core_reset_n SHALL be driven directly from a flop.

Reset
REQ-026 On reset_n=0, regardless of current state, game SHALL be the first enumerator of game_t, the pending register SHALL be cleared, clr_we SHALL be 0, clr_addr SHALL be 0, and core_reset_n SHALL be 0.
REQ-027 After reset_n deasserts, the FSM SHALL run HOLD, SETTLE, CLEAR and RELEASE once with the reset game, so the core is always cleanly reset and RAM is always cleared at power-up.
REQ-028 A reset asserted mid-CLEAR SHALL abandon the clear; the post-reset sequence SHALL restart the clear from address 0.

Structure
REQ-029 The game_t enum SHALL remain in system_consts; the sequencer state enum SHALL be added to system_consts as gsw_state_t.
REQ-030 Cycle counters SHALL be sized from the parameters using $clog2.
REQ-031 The module SHALL contain no sub-module; a single FSM with one shared down-counter for HOLD/SETTLE plus the clr_addr counter SHALL be used.
REQ-032 The parent SHALL instantiate the sequencer with its game output driving the board config block.

Verification
REQ-033 Power-up: release reset_n with defaults -> core_reset_n=0 for 16+2+256 cycles, 256 clr_we pulses at addresses 0..255, then core_reset_n=1 and busy=0.
REQ-034 Switch: in IDLE with game=FINALB, pulse req_valid with DINOREX -> game changes exactly 16 cycles after acceptance, and core_reset_n=1 exactly 274 cycles after acceptance.
REQ-035 Same-game request: pulse req_valid with game_req equal to game -> busy stays 0 and core_reset_n stays 1.
REQ-036 Pending overwrite: during CLEAR, request QJINSEI then LIQUIDK -> after RELEASE a second sequence runs and ends with game=LIQUIDK, with no intermediate QJINSEI.
REQ-037 Mid-clear reset: assert reset_n low at clr_addr=100 -> clr_we drops immediately, game returns to the first enumerator, and after release the clear restarts at address 0.
REQ-038 Parameter corner: with RST_HOLD=1, SETTLE=1, CLR_WORDS=1 -> the sequence takes exactly 3 cycles with core_reset_n=0 and a single clr_we pulse at address 0.
